// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: controller states, default
// operand width and watchdog limit, and the watchdog width helper.
package gcd_pkg;

   // Default operand/result width of the GCD datapath
   localparam int GCD_W           = 8;

   // Default number of WAIT cycles before a job is abandoned
   localparam int TIMEOUT_CYC_DEF = 255;

   // Job controller states: fetch, request, await completion, present result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } gcd_state_e;

   // Bits needed to count 0..timeout_cyc inclusive (at least one bit)
   function automatic int wdog_width(input int timeout_cyc);
      if (timeout_cyc < 1) begin
         return 1;
      end
      return $clog2(timeout_cyc + 1);
   endfunction

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous FIFO holding packed operand pairs ahead of the job controller.
// DEPTH must be a power of two so the pointers wrap naturally.
module gcd_req_fifo
   import gcd_pkg::*;
#(
   parameter int WIDTH = 2 * GCD_W,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   // A full FIFO never accepts a write and an empty one never pops
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rd_data = mem[rd_ptr];

   // Storage array: data only, no reset needed since count gates reads
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap modulo DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/gcd_requester.sv
// Initiator side of the GCD START/DONE handshake. Operand pairs are queued,
// issued one at a time to the responder, and results are returned on a
// valid/ready port. A per-job watchdog turns a missing DONE into a timeout
// result. Optional latency statistics are enabled with the macro
// GCD_REQ_LATENCY_STAT_EN (adds last_lat/max_lat outputs).
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int WIDTH       = GCD_W,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             gcd_start,
   output logic [WIDTH-1:0] gcd_a,
   output logic [WIDTH-1:0] gcd_b,
   input  logic             gcd_done,
   input  logic [WIDTH-1:0] gcd_y,
   input  logic             gcd_error,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_error,
   output logic             out_timeout
`ifdef GCD_REQ_LATENCY_STAT_EN
   ,
   output logic [15:0]      last_lat,
   output logic [15:0]      max_lat
`endif
);

   localparam int WD_W = wdog_width(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
   localparam int CNT_W = $clog2(DEPTH + 1);

   gcd_state_e         state;
   logic [WD_W-1:0]    wdog;
   logic [2*WIDTH-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [CNT_W-1:0]   fifo_count_unused;

   // Watchdog increment that sticks at its limit instead of wrapping
   function automatic logic [WD_W-1:0] wdog_inc(input logic [WD_W-1:0] w);
      if (w == WD_MAX) begin
         return w;
      end
      return w + 1'b1;
   endfunction

   // Upstream queue; the controller only pops while idle
   assign in_ready = !fifo_full;
   assign fifo_pop = (state == IDLE) && !fifo_empty;

   gcd_req_fifo #(
      .WIDTH (2 * WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid),
      .wr_data ({in_a, in_b}),
      .pop     (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count_unused)
   );

   // Job controller: fetch a pair, pulse START, await DONE or timeout, hold result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wdog        <= '0;
         gcd_start   <= 1'b0;
         gcd_a       <= '0;
         gcd_b       <= '0;
         out_valid   <= 1'b0;
         out_y       <= '0;
         out_error   <= 1'b0;
         out_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Operands latch only here, so they stay put through WAIT/HOLD
               if (!fifo_empty) begin
                  gcd_a     <= fifo_head[2*WIDTH-1:WIDTH];
                  gcd_b     <= fifo_head[WIDTH-1:0];
                  gcd_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               gcd_start <= 1'b0;
               wdog      <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // DONE is checked first so it wins over a same-cycle expiry
               if (gcd_done) begin
                  out_y       <= gcd_y;
                  out_error   <= gcd_error;
                  out_timeout <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= HOLD;
               end else if (wdog_inc(wdog) == WD_MAX) begin
                  wdog        <= WD_MAX;
                  out_y       <= '0;
                  out_error   <= 1'b0;
                  out_timeout <= 1'b1;
                  out_valid   <= 1'b1;
                  state       <= HOLD;
               end else begin
                  wdog <= wdog_inc(wdog);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef GCD_REQ_LATENCY_STAT_EN
   // Latency of the completing job: the watchdog has counted the WAIT
   // cycles before this one, so the DONE cycle itself adds one
   function automatic logic [15:0] lat_sat(input logic [WD_W-1:0] w);
      logic [32:0] v;
      v = 33'(w) + 33'd1;
      if (v > 33'h0_0000_FFFF) begin
         return 16'hFFFF;
      end
      return v[15:0];
   endfunction

   logic [15:0] done_lat;
   assign done_lat = lat_sat(wdog);

   // Latency statistics, updated only by real DONE completions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_lat <= 16'd0;
         max_lat  <= 16'd0;
      end else if ((state == WAIT) && gcd_done) begin
         last_lat <= done_lat;
         if (done_lat > max_lat) begin
            max_lat <= done_lat;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural responder, a job-level
// scoreboard checked every cycle, and literal expectations per scenario.
`timescale 1ns/1ps
module tb_gcd_requester;

   localparam int W   = 8;
   localparam int D   = 4;
   localparam int TMO = 16;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         gcd_start;
   logic [W-1:0] gcd_a;
   logic [W-1:0] gcd_b;
   logic         gcd_done;
   logic [W-1:0] gcd_y;
   logic         gcd_error;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_y;
   logic         out_error;
   logic         out_timeout;
`ifdef GCD_REQ_LATENCY_STAT_EN
   logic [15:0]  last_lat;
   logic [15:0]  max_lat;
`endif

   gcd_requester #(
      .WIDTH       (W),
      .DEPTH       (D),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .gcd_start   (gcd_start),
      .gcd_a       (gcd_a),
      .gcd_b       (gcd_b),
      .gcd_done    (gcd_done),
      .gcd_y       (gcd_y),
      .gcd_error   (gcd_error),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .out_error   (out_error),
      .out_timeout (out_timeout)
`ifdef GCD_REQ_LATENCY_STAT_EN
      ,
      .last_lat    (last_lat),
      .max_lat     (max_lat)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event, want none", name);
   endtask

   function automatic int gcd_f(input int a, input int b);
      int x;
      int y;
      int t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // ---------------- behavioural responder ----------------
   int resp_lat    = 3;
   bit resp_silent = 0;
   int inj_req     = 0;
   int inj_ack     = 0;

   initial begin : responder
      int  remain;
      bit  busy;
      int  ra;
      int  rb;
      busy      = 0;
      remain    = 0;
      ra        = 0;
      rb        = 0;
      gcd_done  = 1'b0;
      gcd_y     = '0;
      gcd_error = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         gcd_done  = 1'b0;
         gcd_y     = '0;
         gcd_error = 1'b0;
         if (!rst_n) begin
            busy = 0;
         end else begin
            if (busy) begin
               remain--;
               if (remain == 0) begin
                  busy     = 0;
                  gcd_done = 1'b1;
                  if (ra == 0 || rb == 0) begin
                     gcd_error = 1'b1;
                     gcd_y     = 8'hEE;
                  end else begin
                     gcd_y = 8'(gcd_f(ra, rb));
                  end
               end
            end
            if (gcd_start) begin
               ra = int'(gcd_a);
               rb = int'(gcd_b);
               if (!resp_silent) begin
                  busy   = 1;
                  remain = resp_lat;
               end
            end
            if (inj_req != inj_ack) begin
               inj_ack++;
               gcd_done  = 1'b1;
               gcd_y     = 8'hAA;
               gcd_error = 1'b1;
            end
         end
      end
   end

   // ---------------- downstream ready ----------------
   bit throttle = 0;
   initial begin : sink
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- job-level model and per-cycle compare ----------------
   typedef struct {
      int a;
      int b;
      int y;
      int err;
      int to;
      int lat;
   } job_t;

   job_t job_q[$];
   job_t res_q[$];
   int   res_start[$];
   int   got_y[$];
   int   got_err[$];
   int   got_to[$];
   job_t cj;
   int   cyc        = 0;
   int   pushes     = 0;
   int   starts     = 0;
   bit   prev_vld   = 0;
   bit   prev_rdy   = 0;
   bit   prev_start = 0;
   int   prev_y     = 0;
   int   prev_err   = 0;
   int   prev_to    = 0;
   int   cur_a      = 0;
   int   cur_b      = 0;
   int   m_last     = 0;
   int   m_max      = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         job_q.delete();
         res_q.delete();
         res_start.delete();
         pushes     = 0;
         starts     = 0;
         prev_vld   = 0;
         prev_rdy   = 0;
         prev_start = 0;
         cur_a      = 0;
         cur_b      = 0;
         m_last     = 0;
         m_max      = 0;
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
         check("rst_gcd_start", gcd_start, 0);
         check("rst_out_y", out_y, 0);
      end else begin
         if (gcd_start) begin
            starts++;
            check("start_one_cycle", prev_start, 0);
            check("start_result_pending", res_q.size(), 0);
            if (job_q.size() == 0) begin
               fail("start_without_job");
            end else begin
               cj = job_q.pop_front();
               check("gcd_a_issue", gcd_a, cj.a);
               check("gcd_b_issue", gcd_b, cj.b);
               cur_a = cj.a;
               cur_b = cj.b;
               res_q.push_back(cj);
               res_start.push_back(cyc);
            end
         end else begin
            check("gcd_a_hold", gcd_a, cur_a);
            check("gcd_b_hold", gcd_b, cur_b);
         end

         check("in_ready", in_ready, ((pushes - starts) < D) ? 1 : 0);

         if (prev_vld && !prev_rdy) begin
            check("hold_valid", out_valid, 1);
            check("hold_y", out_y, prev_y);
            check("hold_err", out_error, prev_err);
            check("hold_to", out_timeout, prev_to);
         end
         if (prev_vld && prev_rdy) begin
            check("valid_drop", out_valid, 0);
         end

         if (out_valid && !prev_vld) begin
            if (res_q.size() == 0) begin
               fail("unexpected_out_valid");
            end else begin
               check("result_latency", cyc - res_start[0], res_q[0].lat + 1);
               if (res_q[0].to == 0) begin
                  m_last = res_q[0].lat;
                  if (m_last > m_max) m_max = m_last;
               end
            end
         end

         if (out_valid && out_ready) begin
            if (res_q.size() == 0) begin
               fail("unexpected_handshake");
            end else begin
               cj = res_q.pop_front();
               void'(res_start.pop_front());
               check("out_y", out_y, cj.y);
               check("out_error", out_error, cj.err);
               check("out_timeout", out_timeout, cj.to);
               got_y.push_back(int'(out_y));
               got_err.push_back(int'(out_error));
               got_to.push_back(int'(out_timeout));
            end
         end

`ifdef GCD_REQ_LATENCY_STAT_EN
         check("last_lat", last_lat, m_last);
         check("max_lat", max_lat, m_max);
`endif

         if (in_valid && in_ready) begin
            pushes++;
            cj.a = int'(in_a);
            cj.b = int'(in_b);
            if (resp_silent) begin
               cj.y = 0;  cj.err = 0; cj.to = 1; cj.lat = TMO;
            end else if (cj.a == 0 || cj.b == 0) begin
               cj.y = 238; cj.err = 1; cj.to = 0; cj.lat = resp_lat;
            end else begin
               cj.y = gcd_f(cj.a, cj.b); cj.err = 0; cj.to = 0; cj.lat = resp_lat;
            end
            job_q.push_back(cj);
         end

         prev_vld   = out_valid;
         prev_rdy   = out_ready;
         prev_start = gcd_start;
         prev_y     = int'(out_y);
         prev_err   = int'(out_error);
         prev_to    = int'(out_timeout);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input int a, input int b);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) fail("push_stalled");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((job_q.size() + res_q.size()) != 0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) fail("drain_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input string name, input int idx, input int y,
                             input int err, input int to);
      if (idx >= got_y.size()) begin
         fail({name, "_missing"});
      end else begin
         check({name, "_y"}, got_y[idx], y);
         check({name, "_err"}, got_err[idx], err);
         check({name, "_to"}, got_to[idx], to);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got no end, want finish");
      $fatal(1, "bench timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin : stim
      int base;
      int s0;
      int k;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single job
      resp_lat = 5;
      base     = got_y.size();
      s0       = starts;
      push(21, 6);
      wait_drain();
      expect_res("single", base, 3, 0, 0);
      check("single_starts", starts - s0, 1);

      // burst with a full queue and random downstream stalls
      resp_lat = 3;
      throttle = 1;
      base     = got_y.size();
      push(8, 17);
      push(128, 120);
      push(42, 42);
      push(250, 255);
      push(64, 128);
      @(negedge clk);
      check("burst_full_ready", in_ready, 0);
      wait_drain();
      throttle = 0;
      check("burst_count", got_y.size() - base, 5);
      expect_res("burst0", base + 0, 1, 0, 0);
      expect_res("burst1", base + 1, 8, 0, 0);
      expect_res("burst2", base + 2, 42, 0, 0);
      expect_res("burst3", base + 3, 5, 0, 0);
      expect_res("burst4", base + 4, 64, 0, 0);

      // responder errors followed by a clean job
      resp_lat = 2;
      base     = got_y.size();
      push(35, 0);
      push(0, 42);
      push(0, 0);
      push(128, 110);
      wait_drain();
      expect_res("err0", base + 0, 238, 1, 0);
      expect_res("err1", base + 1, 238, 1, 0);
      expect_res("err2", base + 2, 238, 1, 0);
      expect_res("after_err", base + 3, 2, 0, 0);

      // silent responder: watchdog timeout, then a late DONE is ignored
      resp_silent = 1;
      base        = got_y.size();
      push(9, 6);
      k = 0;
      while (!gcd_start && k < 50) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("tmo_cycles", k, TMO + 1);
      check("tmo_flag", out_timeout, 1);
      check("tmo_y", out_y, 0);
      resp_silent = 0;
      repeat (3) @(negedge clk);
      inj_req++;
      repeat (4) @(negedge clk);
      check("late_done_ignored", out_valid, 0);
      resp_lat = 4;
      push(12, 18);
      wait_drain();
      expect_res("tmo", base, 0, 0, 1);
      expect_res("after_tmo", base + 1, 6, 0, 0);

      // reset while a job is in WAIT and two more are queued
      resp_lat = 12;
      push(40, 30);
      push(9, 3);
      push(7, 5);
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_start", gcd_start, 0);
      check("arst_gcd_a", gcd_a, 0);
      check("arst_gcd_b", gcd_b, 0);
      check("arst_out_y", out_y, 0);
      check("arst_out_timeout", out_timeout, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      inj_req++;
      repeat (4) @(negedge clk);
      check("post_reset_done_ignored", out_valid, 0);
      resp_lat = 5;
      base     = got_y.size();
      @(posedge clk);
      #1;
      push(21, 6);
      wait_drain();
      expect_res("post_reset", base, 3, 0, 0);

`ifdef GCD_REQ_LATENCY_STAT_EN
      // latency statistics
      resp_lat = 4;
      push(6, 4);
      wait_drain();
      check("lat_first", last_lat, 4);
      resp_lat = 9;
      push(10, 5);
      wait_drain();
      check("lat_second", last_lat, 9);
      resp_lat = 6;
      push(9, 3);
      wait_drain();
      check("lat_third", last_lat, 6);
      check("lat_max", max_lat, 9);
      resp_silent = 1;
      push(5, 5);
      wait_drain();
      resp_silent = 0;
      check("lat_after_tmo", last_lat, 6);
      check("max_after_tmo", max_lat, 9);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
